// File: rtl/div_pkg.sv
// Shared definitions for the iterative integer divider: op bit positions,
// controller state encoding and the divide-by-zero quotient constant.
package div_pkg;

    // req_op bit positions
    localparam int OP_SIGNED = 0;
    localparam int OP_REM    = 1;

    // Controller states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_e;

    // Quotient returned for a zero divisor (all ones, sized down to WIDTH at use)
    localparam int            DIV_ZERO_W = 64;
    localparam logic [DIV_ZERO_W-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/div_if.sv
// Request/response handshake bundle between EXE and the divider.
interface div_if #(
    parameter int WIDTH = 32
) ();
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_src1;
    logic [WIDTH-1:0] req_src2;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_result;

    // EXE side
    modport master (
        output req_valid, req_op, req_src1, req_src2, resp_ready,
        input  req_ready, resp_valid, resp_result
    );

    // Divider side
    modport slave (
        input  req_valid, req_op, req_src1, req_src2, resp_ready,
        output req_ready, resp_valid, resp_result
    );
endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract step: brings in the next dividend bit and
// commits the trial subtraction when it does not go negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Trial subtract at WIDTH+1 bits; the top bit is the borrow/sign
    always_comb begin
        shifted = {rem_i, dvd_bit_i};
        trial   = shifted - {1'b0, dvs_i};
        qbit_o  = ~trial[WIDTH];
        rem_o   = qbit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end
endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle divider controller (div/mod, signed/unsigned). Operands are
// converted to magnitudes, divided one bit per cycle, then sign-fixed.
// The dividend register doubles as the quotient shift register.
module div_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    div_if.slave bus,
    output logic busy
);
    state_e           state_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] resp_result_q;
    logic [CNT_W-1:0] cnt_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic             resp_valid_q;

    logic [WIDTH-1:0] rem_d;
    logic             qbit_d;
    logic             accept;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .dvd_bit_i (dvd_q[WIDTH-1]),
        .dvs_i     (dvs_q),
        .rem_o     (rem_d),
        .qbit_o    (qbit_d)
    );

    assign bus.req_ready   = (state_q == IDLE) && !flush && !reset;
    assign accept          = bus.req_valid && bus.req_ready;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_result = resp_result_q;
    assign busy            = (state_q != IDLE);

    // Controller FSM with its datapath registers; flush discards the operation
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            resp_valid_q  <= 1'b0;
            resp_result_q <= '0;
            cnt_q         <= '0;
        end else if (flush) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q  <= bus.req_op;
                        dvd_q <= bus.req_src1;
                        dvs_q <= bus.req_src2;
                        if (bus.req_src2 == '0) begin
                            // Zero divisor short-circuits with no sign fix
                            resp_result_q <= bus.req_op[OP_REM] ? bus.req_src1
                                                                : WIDTH'(DIV_ZERO_Q);
                            resp_valid_q  <= 1'b1;
                            state_q       <= DONE;
                        end else begin
                            state_q <= PREP;
                        end
                    end
                end
                PREP: begin
                    q_neg_q <= op_q[OP_SIGNED] & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                    r_neg_q <= op_q[OP_SIGNED] & dvd_q[WIDTH-1];
                    if (op_q[OP_SIGNED] && dvd_q[WIDTH-1]) dvd_q <= -dvd_q;
                    if (op_q[OP_SIGNED] && dvs_q[WIDTH-1]) dvs_q <= -dvs_q;
                    rem_q   <= '0;
                    cnt_q   <= CNT_W'(WIDTH - 1);
                    state_q <= ITER;
                end
                ITER: begin
                    rem_q <= rem_d;
                    dvd_q <= {dvd_q[WIDTH-2:0], qbit_d};
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) state_q <= FIX;
                end
                FIX: begin
                    if (op_q[OP_REM]) resp_result_q <= r_neg_q ? -rem_q : rem_q;
                    else              resp_result_q <= q_neg_q ? -dvd_q : dvd_q;
                    resp_valid_q <= 1'b1;
                    state_q      <= DONE;
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: a transaction-level reference model
// (arithmetic result plus fixed latency) compared every cycle, directed
// cases with literal expectations, and randomized operations.
module tb_div_ctrl;
    import div_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic busy;
    bit   chk_en = 1'b0;

    div_if #(.WIDTH(W)) bus ();

    div_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference arithmetic computed in 64-bit to sidestep overflow corner cases
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, r;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (op[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        r = op[1] ? (sa % sb) : (sa / sb);
        return r[31:0];
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: one op in flight, result visible a fixed number of cycles after acceptance
    logic        m_busy, m_valid;
    logic [31:0] m_res, m_pend;
    int          m_left;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0; m_valid <= 1'b0; m_left <= 0; m_res <= '0;
        end else if (flush) begin
            m_busy <= 1'b0; m_valid <= 1'b0; m_left <= 0;
        end else if (!m_busy) begin
            if (bus.req_valid) begin
                m_busy <= 1'b1;
                if (bus.req_src2 == 32'd0) begin
                    m_valid <= 1'b1;
                    m_res   <= ref_div(bus.req_op, bus.req_src1, bus.req_src2);
                    m_left  <= 0;
                end else begin
                    m_pend <= ref_div(bus.req_op, bus.req_src1, bus.req_src2);
                    m_left <= W + 2;
                end
            end
        end else if (m_valid) begin
            if (bus.resp_ready) begin
                m_valid <= 1'b0;
                m_busy  <= 1'b0;
            end
        end else begin
            if (m_left == 1) begin
                m_valid <= 1'b1;
                m_res   <= m_pend;
            end
            m_left <= m_left - 1;
        end
    end

    // Compare DUT outputs to the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk1("busy", busy, m_busy);
            chk1("req_ready", bus.req_ready, !m_busy && !flush && !reset);
            chk1("resp_valid", bus.resp_valid, m_valid);
            if (m_valid) chk32("resp_result", bus.resp_result, m_res);
        end
    end

    // Issue one op (entered and left at posedge+1), wait for the result, hold off
    // resp_ready for 'hold' cycles, then handshake.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit pin, output int lat, output logic [31:0] res);
        int t0;
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_src1 = a; bus.req_src2 = b;
        t0 = cyc;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_src1  = $urandom;
        bus.req_src2  = $urandom;
        bus.req_op    = 2'($urandom);
        lat = -1;
        res = 'x;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                lat = cyc - t0;
                res = bus.resp_result;
                break;
            end
        end
        if (lat < 0) begin
            errors++;
            $display("FAIL resp_timeout: no resp_valid within 100 cycles (cycle %0d)", cyc);
            @(posedge clk); #1;
            return;
        end
        for (int k = 0; k < hold; k++) begin
            if (pin) begin
                chk1("hold_valid", bus.resp_valid, 1'b1);
                chk32("hold_result", bus.resp_result, res);
                chk1("hold_req_ready", bus.req_ready, 1'b0);
            end
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
    endtask

    // Issue one op and cancel it with flush in cycle T+k (T = acceptance cycle)
    task automatic do_flush_op(input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input int k);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_src1 = a; bus.req_src2 = b;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (k - 1) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'($urandom_range(1, 15));
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return $urandom >> $urandom_range(0, 31);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [31:0] res;
        logic [1:0]  op;
        logic [31:0] a, b;
        int          seen;

        reset = 1'b1; flush = 1'b0;
        bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_src1 = '0; bus.req_src2 = '0;
        bus.resp_ready = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        @(negedge clk);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_valid", bus.resp_valid, 1'b0);
        chk32("rst_result", bus.resp_result, 32'd0);
        chk1("rst_req_ready", bus.req_ready, 1'b1);
        @(posedge clk); #1;

        // Unsigned divide / remainder
        do_op(2'b00, 32'd100, 32'd7, 0, 1'b0, lat, res);
        chk32("udiv_lat", 32'(lat), 32'd35);
        chk32("udiv_res", res, 32'd14);
        do_op(2'b10, 32'd100, 32'd7, 0, 1'b0, lat, res);
        chk32("urem_res", res, 32'd2);

        // Signed remainder / divide
        do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, lat, res);
        chk32("srem_res", res, 32'hFFFF_FFFF);
        do_op(2'b01, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, lat, res);
        chk32("sdiv_res", res, 32'hFFFF_FFFD);

        // Signed overflow and divide-by-zero
        do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, lat, res);
        chk32("ovf_res", res, 32'h8000_0000);
        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, lat, res);
        chk32("ovf_rem", res, 32'd0);
        do_op(2'b00, 32'd5, 32'd0, 0, 1'b0, lat, res);
        chk32("dz_div_lat", 32'(lat), 32'd1);
        chk32("dz_div_res", res, 32'hFFFF_FFFF);
        do_op(2'b11, 32'd5, 32'd0, 0, 1'b0, lat, res);
        chk32("dz_rem_lat", 32'(lat), 32'd1);
        chk32("dz_rem_res", res, 32'd5);

        // Backpressure: ready low for 10 cycles, handshake on the 11th
        do_op(2'b00, 32'd1000, 32'd10, 10, 1'b1, lat, res);
        chk32("bp_res", res, 32'd100);
        @(negedge clk);
        chk1("bp_idle_busy", busy, 1'b0);
        chk1("bp_idle_valid", bus.resp_valid, 1'b0);
        chk1("bp_idle_ready", bus.req_ready, 1'b1);
        @(posedge clk); #1;

        // Flush in the 10th ITER cycle
        do_flush_op(2'b01, 32'd12345, 32'd77, 11);
        @(negedge clk);
        chk1("fl_busy", busy, 1'b0);
        chk1("fl_req_ready", bus.req_ready, 1'b1);
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        chk32("fl_no_valid", 32'(seen), 32'd0);
        @(posedge clk); #1;
        do_op(2'b00, 32'd81, 32'd9, 0, 1'b0, lat, res);
        chk32("fl_after_res", res, 32'd9);

        // Reset mid-operation
        bus.req_valid = 1'b1; bus.req_op = 2'b00; bus.req_src1 = 32'd999; bus.req_src2 = 32'd3;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk1("rm_busy", busy, 1'b0);
        chk1("rm_valid", bus.resp_valid, 1'b0);
        chk32("rm_result", bus.resp_result, 32'd0);
        chk1("rm_req_ready", bus.req_ready, 1'b1);
        @(posedge clk); #1;

        // Flush coincident with req_valid in IDLE: nothing accepted
        bus.req_valid = 1'b1; bus.req_op = 2'b00; bus.req_src1 = 32'd50; bus.req_src2 = 32'd5;
        flush = 1'b1;
        @(negedge clk);
        chk1("fv_req_ready", bus.req_ready, 1'b0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        flush = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.resp_valid || busy) seen++;
        end
        chk32("fv_no_activity", 32'(seen), 32'd0);
        @(posedge clk); #1;

        // Randomized operations with backpressure and occasional flushes
        for (int i = 0; i < 150; i++) begin
            op = 2'($urandom);
            a  = rand_operand();
            b  = rand_operand();
            if ($urandom_range(0, 9) == 0) begin
                do_flush_op(op, a, b, $urandom_range(1, 40));
            end else begin
                do_op(op, a, b, $urandom_range(0, 3), 1'b0, lat, res);
                chk32("rnd_lat", 32'(lat), (b == 32'd0) ? 32'd1 : 32'd35);
            end
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Multi-cycle controller and iterative datapath for the integer divider (div.w, div.wu, mod.w, mod.wu) used by the EXE stage.
- Accepts one operation per request handshake and runs a 1-bit-per-cycle restoring shift-subtract loop.
- Presents the result through a valid/ready handshake; EXE stalls on it the same way it stalls on ALU complete.
- Supports pipeline flush (exception/branch cancel) at any cycle.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.
- CNT_W, 5, iteration counter width, must equal clog2(WIDTH).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  cancel any in-flight operation and drop any same-cycle request.
- req_valid  input  1  EXE presents an operation.
- req_ready  output  1  controller can accept; high only in IDLE and when flush is low.
- req_op  input  2  bit0 = signed, bit1 = return remainder (else quotient).
- req_src1  input  WIDTH  dividend.
- req_src2  input  WIDTH  divisor.
- resp_valid  output  1  result available; held until consumed.
- resp_ready  input  1  EXE/MEM side accepts the result.
- resp_result  output  WIDTH  quotient or remainder.
- busy  output  1  high in any state other than IDLE, for hazard and stall logic.

Behaviour:
- Reset values: state = IDLE, resp_valid = 0, resp_result = 0, busy = 0, counter = 0; req_ready = 1 in the cycle after reset deasserts.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE: on req_valid & req_ready, latch op and operands.
  - If src2 == 0, go to DONE.
  - Otherwise go to PREP.
- Divide-by-zero result: remainder op returns src1 unmodified; quotient op returns all ones. No sign fix is applied.
- PREP:
  - If signed, take absolute values and latch q_neg = sign1 ^ sign2 and r_neg = sign1.
  - Clear the partial remainder, load the counter with WIDTH-1, go to ITER.
- ITER, one quotient bit per cycle, MSB first:
  - Shift the remainder left and bring in the next dividend bit.
  - Trial subtract at WIDTH+1 bits. If non-negative, commit it and set quotient bit = 1; otherwise quotient bit = 0.
  - Counter decrements; on counter == 0, go to FIX after that cycle's step.
- FIX: negate the quotient if q_neg, negate the remainder if r_neg, select per op bit1, register into resp_result, go to DONE.
- DONE: resp_valid = 1. On resp_ready, go to IDLE and drop resp_valid the next cycle. resp_result is stable while resp_valid & ~resp_ready.
- Latency, with acceptance at cycle T:
  - Normal path: resp_valid first high at T+WIDTH+3 (T+35 for WIDTH = 32).
  - Divide-by-zero: resp_valid first high at T+1.
  - Back-to-back: the next request can be accepted in the cycle after the response handshake.
- Signed overflow (src1 = 0x80000000, src2 = -1): quotient 0x80000000, remainder 0. This falls out of the magnitude arithmetic with no special casing.
- Flush:
  - Has priority over everything except reset. In any state, flush forces IDLE on the next edge, clears resp_valid and discards the operation.
  - flush together with req_valid in IDLE: req_ready is 0, so nothing is accepted.
  - flush together with resp_valid & resp_ready in DONE: the handshake completes and the controller returns to IDLE.
- Reset mid-operation: identical to flush, and additionally clears resp_result.
- req_src1, req_src2 and req_op are sampled only at acceptance. Later changes on them have no effect.

Decomposition:
- Shared package div_pkg:
  - op bit positions: OP_SIGNED = 0, OP_REM = 1.
  - state encoding, 3-bit localparams: IDLE, PREP, ITER, FIX, DONE.
  - DIV_ZERO_Q = all ones.
- Sub-module div_step (combinational):
  - inputs: partial remainder, next dividend bit, divisor magnitude.
  - outputs: next remainder, quotient bit.
  - Keeps the FSM/counter logic in div_ctrl separate from the arithmetic and allows a later radix-4 swap.

Test Plan:
- Unsigned divide: op = 00, 100 / 7, accepted at T -> resp_valid at T+35, result 14; same operands with op = 10 -> result 2.
- Signed remainder: op = 11, -7 (0xFFFFFFF9) % 2 -> 0xFFFFFFFF; op = 01, -7 / 2 -> 0xFFFFFFFD.
- Signed overflow and divide-by-zero:
  - op = 01, 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - op = 00, 5 / 0 -> 0xFFFFFFFF at T+1.
  - op = 11, 5 % 0 -> 5 at T+1.
- Backpressure: hold resp_ready = 0 for 10 cycles after resp_valid -> resp_valid and resp_result stay constant; req_ready stays 0; handshake on cycle 11 -> IDLE next cycle.
- Flush mid-ITER: flush on the 10th ITER cycle -> busy = 0 and req_ready = 1 next cycle, no resp_valid ever; a new 81 / 9 request then completes with result 9.
- Reset mid-operation, and flush coincident with req_valid in IDLE -> no acceptance, all outputs at reset values, no spurious resp_valid.
